// File: rtl/alu_rs_scheduler_pkg.sv
// Shared types for the ALU reservation station: opcodes, tags, entry layout
// and the CDB snoop helper used by both dispatch bypass and wakeup.
package alu_rs_scheduler_pkg;

  localparam int DATA_W       = 32;
  localparam int ROB_ID_W     = 4;
  localparam int RS_SIZE_DFLT = 8;
  localparam int RS_IDX_DFLT  = 3;

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [ROB_ID_W-1:0] rob_id_t;

  typedef enum logic [3:0] {
    NOP     = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_ADDI = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_XOR  = 4'd6,
    OP_SLT  = 4'd7,
    OP_BEQ  = 4'd8,
    OP_BNE  = 4'd9,
    OP_JAL  = 4'd10,
    OP_JALR = 4'd11
  } opcode_t;

  typedef struct packed {
    logic    busy;
    rob_id_t tag;
    data_t   val;
  } operand_t;

  typedef struct packed {
    opcode_t  optype;
    rob_id_t  rd_alias;
    data_t    pc;
    data_t    imm;
    operand_t op1;
    operand_t op2;
  } entry_t;

  // Resolve a pending operand against both CDBs; the ALU bus has priority
  // when both broadcast the same tag in one cycle.
  function automatic operand_t snoop(input operand_t op,
                                     input logic alu_v, input rob_id_t alu_a, input data_t alu_d,
                                     input logic lsb_v, input rob_id_t lsb_a, input data_t lsb_d);
    operand_t r;
    r = op;
    if (op.busy) begin
      if (alu_v && (alu_a == op.tag)) begin
        r.busy = 1'b0;
        r.val  = alu_d;
      end else if (lsb_v && (lsb_a == op.tag)) begin
        r.busy = 1'b0;
        r.val  = lsb_d;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_scheduler_priority_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module rs_priority_enc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  // Scan from the top down so the lowest set bit is the last to win.
  always_comb begin
    idx = '0;
    vld = |req;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// Integer ALU reservation station: holds dispatched ops, snoops the ALU and
// LSB CDBs for pending operands, and issues the lowest-index ready entry
// into a registered ALU operand stage each cycle.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
#(
  parameter int RS_SIZE  = RS_SIZE_DFLT,
  parameter int RS_IDX_W = RS_IDX_DFLT
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    rdy,
  input  logic    clear,
  input  logic    disp_valid,
  input  opcode_t disp_optype,
  input  rob_id_t disp_rd_alias,
  input  data_t   disp_pc,
  input  data_t   disp_imm,
  input  logic    disp_q1_busy,
  input  logic    disp_q2_busy,
  input  rob_id_t disp_q1,
  input  rob_id_t disp_q2,
  input  data_t   disp_v1,
  input  data_t   disp_v2,
  output logic    full,
  input  logic    cdb_alu_valid,
  input  logic    cdb_lsb_valid,
  input  rob_id_t cdb_alu_alias,
  input  rob_id_t cdb_lsb_alias,
  input  data_t   cdb_alu_value,
  input  data_t   cdb_lsb_value,
  output opcode_t alu_optype,
  output rob_id_t alu_rd_alias,
  output data_t   alu_pc,
  output data_t   alu_rs1,
  output data_t   alu_rs2,
  output data_t   alu_imm
);

  logic               busy_reg [RS_SIZE];
  entry_t             entry_reg [RS_SIZE];
  logic [RS_SIZE-1:0] busy_vec;
  logic [RS_SIZE-1:0] ready_vec;

  logic [RS_IDX_W-1:0] free_idx;
  logic                free_vld;
  logic [RS_IDX_W-1:0] sel_idx;
  logic                sel_vld;
  logic                disp_fire;
  logic                issue_fire;
  entry_t              disp_entry;

  opcode_t alu_optype_reg;
  rob_id_t alu_rd_alias_reg;
  data_t   alu_pc_reg;
  data_t   alu_rs1_reg;
  data_t   alu_rs2_reg;
  data_t   alu_imm_reg;

  // Both searches look at pre-edge state, so the slot being issued is still
  // busy and can never be picked as this cycle's free slot.
  rs_priority_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_enc (
    .req (~busy_vec),
    .idx (free_idx),
    .vld (free_vld)
  );

  rs_priority_enc #(.N(RS_SIZE), .IDX_W(RS_IDX_W)) u_sel_enc (
    .req (ready_vec),
    .idx (sel_idx),
    .vld (sel_vld)
  );

  assign full       = &busy_vec;
  assign disp_fire  = disp_valid && free_vld && !clear && rdy;
  assign issue_fire = sel_vld && !clear && rdy;

  // Incoming op with same-cycle CDB bypass applied to each operand.
  always_comb begin
    disp_entry          = '0;
    disp_entry.optype   = disp_optype;
    disp_entry.rd_alias = disp_rd_alias;
    disp_entry.pc       = disp_pc;
    disp_entry.imm      = disp_imm;
    disp_entry.op1      = snoop('{busy: disp_q1_busy, tag: disp_q1, val: disp_v1},
                                cdb_alu_valid, cdb_alu_alias, cdb_alu_value,
                                cdb_lsb_valid, cdb_lsb_alias, cdb_lsb_value);
    disp_entry.op2      = snoop('{busy: disp_q2_busy, tag: disp_q2, val: disp_v2},
                                cdb_alu_valid, cdb_alu_alias, cdb_alu_value,
                                cdb_lsb_valid, cdb_lsb_alias, cdb_lsb_value);
  end

  generate
    for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_entry
      entry_t woke;

      assign busy_vec[gi]  = busy_reg[gi];
      assign ready_vec[gi] = busy_reg[gi] && !entry_reg[gi].op1.busy && !entry_reg[gi].op2.busy;

      // Entry contents after snooping both CDBs this cycle.
      always_comb begin
        woke     = entry_reg[gi];
        woke.op1 = snoop(entry_reg[gi].op1,
                         cdb_alu_valid, cdb_alu_alias, cdb_alu_value,
                         cdb_lsb_valid, cdb_lsb_alias, cdb_lsb_value);
        woke.op2 = snoop(entry_reg[gi].op2,
                         cdb_alu_valid, cdb_alu_alias, cdb_alu_value,
                         cdb_lsb_valid, cdb_lsb_alias, cdb_lsb_value);
      end

      // Per-entry state: flush beats issue, issue beats dispatch, else wakeup.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          busy_reg[gi]  <= 1'b0;
          entry_reg[gi] <= '0;
        end else if (clear) begin
          busy_reg[gi] <= 1'b0;
        end else if (rdy) begin
          if (issue_fire && (sel_idx == RS_IDX_W'(gi))) begin
            busy_reg[gi] <= 1'b0;
          end else if (disp_fire && (free_idx == RS_IDX_W'(gi))) begin
            busy_reg[gi]  <= 1'b1;
            entry_reg[gi] <= disp_entry;
          end else if (busy_reg[gi]) begin
            entry_reg[gi] <= woke;
          end
        end
      end
    end
  endgenerate

  // ALU operand stage: loads the selected entry, otherwise presents NOP and
  // holds the remaining fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_optype_reg   <= NOP;
      alu_rd_alias_reg <= '0;
      alu_pc_reg       <= '0;
      alu_rs1_reg      <= '0;
      alu_rs2_reg      <= '0;
      alu_imm_reg      <= '0;
    end else if (issue_fire) begin
      alu_optype_reg   <= entry_reg[sel_idx].optype;
      alu_rd_alias_reg <= entry_reg[sel_idx].rd_alias;
      alu_pc_reg       <= entry_reg[sel_idx].pc;
      alu_rs1_reg      <= entry_reg[sel_idx].op1.val;
      alu_rs2_reg      <= entry_reg[sel_idx].op2.val;
      alu_imm_reg      <= entry_reg[sel_idx].imm;
    end else begin
      alu_optype_reg <= NOP;
    end
  end

  assign alu_optype   = alu_optype_reg;
  assign alu_rd_alias = alu_rd_alias_reg;
  assign alu_pc       = alu_pc_reg;
  assign alu_rs1      = alu_rs1_reg;
  assign alu_rs2      = alu_rs2_reg;
  assign alu_imm      = alu_imm_reg;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Scoreboard bench for alu_rs_scheduler: directed stimulus pushes expected
// issues, a negedge monitor pops and compares every non-NOP ALU output.
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n, rdy, clear, disp_valid;
  opcode_t disp_optype;
  rob_id_t disp_rd_alias, disp_q1, disp_q2;
  data_t   disp_pc, disp_imm, disp_v1, disp_v2;
  logic    disp_q1_busy, disp_q2_busy, full;
  logic    cdb_alu_valid, cdb_lsb_valid;
  rob_id_t cdb_alu_alias, cdb_lsb_alias;
  data_t   cdb_alu_value, cdb_lsb_value;
  opcode_t alu_optype;
  rob_id_t alu_rd_alias;
  data_t   alu_pc, alu_rs1, alu_rs2, alu_imm;

  typedef struct packed {
    opcode_t op;
    rob_id_t rd;
    data_t   pc;
    data_t   rs1;
    data_t   rs2;
    data_t   imm;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  alu_rs_scheduler dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear),
    .disp_valid(disp_valid), .disp_optype(disp_optype), .disp_rd_alias(disp_rd_alias),
    .disp_pc(disp_pc), .disp_imm(disp_imm),
    .disp_q1_busy(disp_q1_busy), .disp_q2_busy(disp_q2_busy),
    .disp_q1(disp_q1), .disp_q2(disp_q2), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .full(full),
    .cdb_alu_valid(cdb_alu_valid), .cdb_lsb_valid(cdb_lsb_valid),
    .cdb_alu_alias(cdb_alu_alias), .cdb_lsb_alias(cdb_lsb_alias),
    .cdb_alu_value(cdb_alu_value), .cdb_lsb_value(cdb_lsb_value),
    .alu_optype(alu_optype), .alu_rd_alias(alu_rd_alias), .alu_pc(alu_pc),
    .alu_rs1(alu_rs1), .alu_rs2(alu_rs2), .alu_imm(alu_imm)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    disp_valid    = 1'b0;
    clear         = 1'b0;
    cdb_alu_valid = 1'b0;
    cdb_lsb_valid = 1'b0;
  endtask

  task automatic set_disp(input opcode_t op, input int rd, input int pc, input int imm,
                          input logic q1b, input int q1, input int v1,
                          input logic q2b, input int q2, input int v2);
    disp_valid    = 1'b1;
    disp_optype   = op;
    disp_rd_alias = rob_id_t'(rd);
    disp_pc       = data_t'(pc);
    disp_imm      = data_t'(imm);
    disp_q1_busy  = q1b;
    disp_q1       = rob_id_t'(q1);
    disp_v1       = data_t'(v1);
    disp_q2_busy  = q2b;
    disp_q2       = rob_id_t'(q2);
    disp_v2       = data_t'(v2);
  endtask

  task automatic push_exp(input opcode_t op, input int rd, input int pc,
                          input int rs1, input int rs2, input int imm);
    exp_q.push_back('{op, rob_id_t'(rd), data_t'(pc), data_t'(rs1), data_t'(rs2), data_t'(imm)});
  endtask

  // Let any outstanding issues appear, then require the scoreboard empty.
  task automatic drain(input string name, input int n);
    repeat (n) tick();
    check({"drain_", name}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Monitor: every non-NOP ALU output is one transaction to score.
  initial begin
    exp_t got, e;
    forever begin
      @(negedge clk);
      if (rst_n && alu_optype != NOP) begin
        got = '{alu_optype, alu_rd_alias, alu_pc, alu_rs1, alu_rs2, alu_imm};
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_issue actual op=%s rd=%0d pc=%0h rs1=%0h rs2=%0h imm=%0h required none",
                   got.op.name(), got.rd, got.pc, got.rs1, got.rs2, got.imm);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL issue actual op=%s rd=%0d pc=%0h rs1=%0h rs2=%0h imm=%0h required op=%s rd=%0d pc=%0h rs1=%0h rs2=%0h imm=%0h",
                     got.op.name(), got.rd, got.pc, got.rs1, got.rs2, got.imm,
                     e.op.name(), e.rd, e.pc, e.rs1, e.rs2, e.imm);
          end else begin
            $display("issue op=%s rd=%0d pc=%0h rs1=%0h rs2=%0h imm=%0h ok",
                     got.op.name(), got.rd, got.pc, got.rs1, got.rs2, got.imm);
          end
        end
      end
    end
  end

  initial begin
    idle_inputs();
    rdy = 1'b1;
    rst_n = 1'b0;
    set_disp(NOP, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    disp_valid = 1'b0;
    cdb_alu_alias = '0; cdb_lsb_alias = '0; cdb_alu_value = '0; cdb_lsb_value = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_full", 64'(full), 64'd0);
    check("rst_optype", 64'(alu_optype), 64'(NOP));
    check("rst_rd", 64'(alu_rd_alias), 64'd0);
    check("rst_pc", 64'(alu_pc), 64'd0);
    check("rst_rs1", 64'(alu_rs1), 64'd0);
    check("rst_rs2", 64'(alu_rs2), 64'd0);
    check("rst_imm", 64'(alu_imm), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic: ready ADDI, visible two edges after dispatch, then NOP.
    set_disp(OP_ADDI, 1, 'h100, 3, 0, 0, 5, 0, 0, 0);
    push_exp(OP_ADDI, 1, 'h100, 5, 0, 3);
    tick();
    idle_inputs();
    check("basic_lat1", 64'(alu_optype), 64'(NOP));
    tick();
    check("basic_lat2", 64'(alu_optype), 64'(OP_ADDI));
    tick();
    check("basic_after", 64'(alu_optype), 64'(NOP));
    drain("basic", 3);

    // Wakeup from LSB CDB.
    set_disp(OP_ADD, 2, 'h104, 0, 1, 4, 0, 0, 0, 7);
    tick();
    idle_inputs();
    repeat (3) tick();
    cdb_lsb_valid = 1'b1; cdb_lsb_alias = 4'd4; cdb_lsb_value = 32'd10;
    push_exp(OP_ADD, 2, 'h104, 10, 7, 0);
    tick();
    idle_inputs();
    check("wake_lat1", 64'(alu_optype), 64'(NOP));
    tick();
    check("wake_lat2", 64'(alu_optype), 64'(OP_ADD));
    drain("wake", 3);

    // Both CDBs match the same tag: ALU value wins; second operand waits.
    set_disp(OP_SUB, 3, 'h108, 0, 1, 5, 0, 1, 6, 0);
    tick();
    idle_inputs();
    cdb_alu_valid = 1'b1; cdb_alu_alias = 4'd5; cdb_alu_value = 32'd11;
    cdb_lsb_valid = 1'b1; cdb_lsb_alias = 4'd5; cdb_lsb_value = 32'd22;
    tick();
    idle_inputs();
    repeat (2) tick();
    cdb_lsb_valid = 1'b1; cdb_lsb_alias = 4'd6; cdb_lsb_value = 32'd33;
    push_exp(OP_SUB, 3, 'h108, 11, 33, 0);
    tick();
    idle_inputs();
    drain("prio", 4);

    // Dispatch bypass from ALU CDB.
    set_disp(OP_BEQ, 4, 'h10c, 'h20, 1, 2, 0, 0, 0, 9);
    cdb_alu_valid = 1'b1; cdb_alu_alias = 4'd2; cdb_alu_value = 32'd9;
    push_exp(OP_BEQ, 4, 'h10c, 9, 9, 'h20);
    tick();
    idle_inputs();
    check("byp_lat1", 64'(alu_optype), 64'(NOP));
    tick();
    check("byp_lat2", 64'(alu_optype), 64'(OP_BEQ));
    drain("byp", 3);

    // Fill all entries waiting on tag 1; extra dispatch must be ignored.
    for (int i = 0; i < 8; i++) begin
      set_disp(OP_ADD, i, 'h200 + 4 * i, i, 1, 1, 0, 0, 0, 'h30 + i);
      tick();
    end
    idle_inputs();
    check("fill_full", 64'(full), 64'd1);
    set_disp(OP_XOR, 15, 'h300, 0, 0, 0, 1, 0, 0, 2);
    tick();
    idle_inputs();
    check("fill_full_hold", 64'(full), 64'd1);
    cdb_alu_valid = 1'b1; cdb_alu_alias = 4'd1; cdb_alu_value = 32'h50;
    for (int i = 0; i < 8; i++) push_exp(OP_ADD, i, 'h200 + 4 * i, 'h50, 'h30 + i, i);
    tick();
    idle_inputs();
    check("fill_full_wake", 64'(full), 64'd1);
    tick();
    check("fill_full_drop", 64'(full), 64'd0);
    drain("fill", 10);

    // Flush: pending entries, a ready entry about to issue, same-cycle dispatch.
    for (int i = 0; i < 3; i++) begin
      set_disp(OP_OR, 5 + i, 'h400 + 4 * i, 0, 1, 6, 0, 0, 0, 1);
      tick();
    end
    set_disp(OP_AND, 8, 'h410, 0, 0, 0, 1, 0, 0, 1);
    tick();
    set_disp(OP_AND, 9, 'h414, 0, 0, 0, 1, 0, 0, 1);
    clear = 1'b1;
    tick();
    idle_inputs();
    check("flush_full", 64'(full), 64'd0);
    check("flush_optype", 64'(alu_optype), 64'(NOP));
    cdb_alu_valid = 1'b1; cdb_alu_alias = 4'd6; cdb_alu_value = 32'h77;
    tick();
    idle_inputs();
    drain("flush", 5);

    // Stall: rdy=0 blocks issue and dispatch until released.
    set_disp(OP_SLT, 10, 'h500, 0, 0, 0, 3, 0, 0, 4);
    tick();
    rdy = 1'b0;
    set_disp(OP_JAL, 11, 'h504, 0, 0, 0, 1, 0, 0, 1);
    repeat (3) begin
      tick();
      check("stall_nop", 64'(alu_optype), 64'(NOP));
    end
    idle_inputs();
    push_exp(OP_SLT, 10, 'h500, 3, 4, 0);
    rdy = 1'b1;
    tick();
    check("stall_release", 64'(alu_optype), 64'(OP_SLT));
    drain("stall", 4);

    // Asynchronous reset in the middle of back-to-back issues.
    for (int i = 0; i < 3; i++) begin
      set_disp(OP_ADD, 12 + i, 'h600 + 4 * i, 0, 0, 0, i, 0, 0, 1);
      push_exp(OP_ADD, 12 + i, 'h600 + 4 * i, i, 1, 0);
      tick();
    end
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("arst_optype", 64'(alu_optype), 64'(NOP));
    check("arst_rd", 64'(alu_rd_alias), 64'd0);
    check("arst_pc", 64'(alu_pc), 64'd0);
    check("arst_rs1", 64'(alu_rs1), 64'd0);
    check("arst_full", 64'(full), 64'd0);
    check("arst_pending", 64'(exp_q.size()), 64'd2);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    drain("arst", 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
